// File: rtl/adder_tree_feeder.sv
// Serial-to-8-lane feeder for the pipelined adder tree, with flush and sum-valid tracking.
// Optional macro ADDER_FEEDER_HEADROOM_EN clamps samples and adds CLIP_CNT.
module adder_tree_feeder #(
  parameter int WIDTH    = 16,
  parameter int TREE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic             VEC_VALID,
  output logic             SUM_VALID,
  output logic [2:0]       FILL,
`ifdef ADDER_FEEDER_HEADROOM_EN
  output logic [CNT_W-1:0] CLIP_CNT,
`endif
  output logic [CNT_W-1:0] VEC_CNT
);

  logic [WIDTH-1:0]    sample;
  logic [WIDTH-1:0]    stage [7];
  logic [WIDTH-1:0]    lane  [8];
  logic [TREE_LAT-1:0] dly;
  logic                last;
  logic                emit;

`ifdef ADDER_FEEDER_HEADROOM_EN
  // Cap keeps 8 lanes summed below 2^WIDTH.
  localparam logic [WIDTH-1:0] CAP = {3'b000, {(WIDTH-3){1'b1}}};
  logic clip;
  assign clip   = IN_DATA > CAP;
  assign sample = clip ? CAP : IN_DATA;
`else
  assign sample = IN_DATA;
`endif

  assign last = IN_VALID && (FILL == 3'd7);
  assign emit = last || (FLUSH && (IN_VALID || (FILL != 3'd0)));

  // Lanes at or above the effective count stay zero.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      lane[i] = '0;
      if (3'(i) < FILL)
        lane[i] = stage[i];
      if (IN_VALID && (FILL == 3'(i)))
        lane[i] = sample;
    end
    lane[7] = last ? sample : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      E         <= '0;
      F         <= '0;
      G         <= '0;
      H         <= '0;
      VEC_VALID <= 1'b0;
      FILL      <= 3'd0;
      VEC_CNT   <= '0;
      for (int i = 0; i < 7; i++)
        stage[i] <= '0;
    end else begin
      VEC_VALID <= emit;
      if (emit) begin
        A       <= lane[0];
        B       <= lane[1];
        C       <= lane[2];
        D       <= lane[3];
        E       <= lane[4];
        F       <= lane[5];
        G       <= lane[6];
        H       <= lane[7];
        VEC_CNT <= VEC_CNT + 1'b1;
        FILL    <= 3'd0;
        for (int i = 0; i < 7; i++)
          stage[i] <= '0;
      end else if (IN_VALID) begin
        for (int i = 0; i < 7; i++)
          if (FILL == 3'(i))
            stage[i] <= sample;
        FILL <= FILL + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly <= '0;
    end else begin
      dly[0] <= VEC_VALID;
      for (int i = 1; i < TREE_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  assign SUM_VALID = dly[TREE_LAT-1];

`ifdef ADDER_FEEDER_HEADROOM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      CLIP_CNT <= '0;
    else if (IN_VALID && clip)
      CLIP_CNT <= CLIP_CNT + 1'b1;
  end
`endif

endmodule
